// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: UART transmit sequencer that frames one parallel word as
// start / data (LSB first) / optional parity / stop. It drives the select and
// operands of an external registered TX mux that shares the TX_tick baud strobe.
// Optional build macro: UART_TX_TWO_STOP_EN selects two stop bits instead of one.
module uart_tx_fsm #(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              TX_tick,
  input  logic [DATA_W-1:0] P_DATA,
  input  logic              Data_Valid,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  output logic [1:0]        MUX_SEL,
  output logic              ser_data,
  output logic              par_bit,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_bit_q, par_bit_d;
  logic              par_en_q, par_en_d;
`ifdef UART_TX_TWO_STOP_EN
  logic              stop_cnt_q, stop_cnt_d;
`endif

  // Next-state and datapath updates; every move except accept waits for TX_tick.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can leave
    // it unassigned and infer a latch; blocking '=' is correct in combinational code.
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    par_en_d  = par_en_q;
`ifdef UART_TX_TWO_STOP_EN
    stop_cnt_d = stop_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        // Accept does not need a tick; a coincident tick still sends idle '1'.
        if (Data_Valid) begin
          shift_d   = P_DATA;
          par_en_d  = PAR_EN;
          par_bit_d = (^P_DATA) ^ PAR_TYP;
          state_d   = START;
        end
      end
      START: begin
        if (TX_tick) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (TX_tick) begin
          shift_d = shift_q >> 1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (TX_tick) state_d = STOP;
      end
      STOP: begin
`ifdef UART_TX_TWO_STOP_EN
        if (TX_tick) begin
          if (stop_cnt_q) begin
            stop_cnt_d = 1'b0;
            state_d    = IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
`else
        if (TX_tick) state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any frame and idles the line.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop_cnt_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking '<=' so all flops update from pre-edge values together.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      par_en_q  <= par_en_d;
`ifdef UART_TX_TWO_STOP_EN
      stop_cnt_q <= stop_cnt_d;
`endif
    end
  end

  // Mux select decoded from the state register only, so it is glitch-free per tick.
  always_comb begin
    MUX_SEL = 2'b11;
    unique case (state_q)
      START:   MUX_SEL = 2'b00;
      DATA:    MUX_SEL = 2'b01;
      PARITY:  MUX_SEL = 2'b10;
      default: MUX_SEL = 2'b11;
    endcase
  end

  assign ser_data = shift_q[0];
  assign par_bit  = par_bit_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb_uart_tx_fsm: directed bench for uart_tx_fsm. Reconstructs the serial line
// from MUX_SEL/ser_data/par_bit as the external mux would on each TX_tick and
// compares it against frames built from the stimulus word.
module tb_uart_tx_fsm;

  localparam int DW = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int N_STOP = 2;
`else
  localparam int N_STOP = 1;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          TX_tick = 1'b0;
  logic [DW-1:0] P_DATA = '0;
  logic          Data_Valid = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [1:0]    MUX_SEL;
  logic          ser_data;
  logic          par_bit;
  logic          busy;

  int n_cmp  = 0;
  int n_fail = 0;

  uart_tx_fsm #(.DATA_W(DW)) dut (
    .CLK(CLK), .RST(RST), .TX_tick(TX_tick), .P_DATA(P_DATA),
    .Data_Valid(Data_Valid), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .MUX_SEL(MUX_SEL), .ser_data(ser_data), .par_bit(par_bit), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line bit idx of a frame, built from the word and settings alone.
  function automatic logic exp_bit(input logic [DW-1:0] d, input logic pen,
                                   input logic ptyp, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DW) return d[idx-1];
    if (pen && idx == DW + 1) return (^d) ^ ptyp;
    return 1'b1;
  endfunction

  // One baud tick: the line value is what the mux selects just before the edge.
  task automatic tick(input logic dv, output logic line, output logic b);
    @(negedge CLK);
    case (MUX_SEL)
      2'b00:   line = 1'b0;
      2'b01:   line = ser_data;
      2'b10:   line = par_bit;
      default: line = 1'b1;
    endcase
    b = busy;
    TX_tick = 1'b1;
    Data_Valid = dv;
    @(posedge CLK);
    #1;
    TX_tick = 1'b0;
    Data_Valid = 1'b0;
  endtask

  task automatic accept(input logic [DW-1:0] d, input logic pen, input logic ptyp);
    @(posedge CLK);
    #1;
    P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; Data_Valid = 1'b1;
    @(posedge CLK);
    #1;
    Data_Valid = 1'b0;
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_par_bit", 32'(par_bit), 32'((^d) ^ ptyp));
  endtask

  // Send all ticks of a frame; optionally glitch Data_Valid mid-frame and/or
  // raise Data_Valid on the final (STOP->IDLE) tick.
  task automatic frame_ticks(input logic [DW-1:0] d, input logic pen, input logic ptyp,
                             input int glitch_at, input logic end_dv, input string tag);
    int flen;
    logic line, b;
    flen = 1 + DW + int'(pen) + N_STOP;
    for (int i = 0; i < flen; i++) begin
      repeat (15) @(posedge CLK);
      #1;
      if (i == glitch_at) begin
        P_DATA = 8'hFF; PAR_EN = ~pen; PAR_TYP = ~ptyp; Data_Valid = 1'b1;
        @(posedge CLK);
        #1;
        Data_Valid = 1'b0;
      end
      tick(end_dv && (i == flen - 1), line, b);
      check({tag, "_busy"}, 32'(b), 32'd1);
      check({tag, "_bit"}, 32'(line), 32'(exp_bit(d, pen, ptyp, i)));
    end
    @(negedge CLK);
    check({tag, "_end_busy"}, 32'(busy), 32'd0);
    check({tag, "_end_sel"}, 32'(MUX_SEL), 32'd3);
  endtask

  initial begin
    logic line, b;

    // Reset values.
    #12;
    check("rst_sel", 32'(MUX_SEL), 32'd3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ser", 32'(ser_data), 32'd0);
    check("rst_par", 32'(par_bit), 32'd0);
    RST = 1'b1;

    // Idle with ticks: line stays 1.
    tick(1'b0, line, b);
    check("idle_bit", 32'(line), 32'd1);
    check("idle_busy", 32'(b), 32'd0);

    // 0xA5 no parity: 0,1,0,1,0,0,1,0,1,1.
    accept(8'hA5, 1'b0, 1'b0);
    frame_ticks(8'hA5, 1'b0, 1'b0, -1, 1'b0, "a5_np");

    // 0xA5 even parity -> par 0; odd parity -> par 1.
    accept(8'hA5, 1'b1, 1'b0);
    frame_ticks(8'hA5, 1'b1, 1'b0, -1, 1'b0, "a5_even");
    accept(8'hA5, 1'b1, 1'b1);
    frame_ticks(8'hA5, 1'b1, 1'b1, -1, 1'b0, "a5_odd");

    // Data_Valid together with a tick in IDLE: that tick sends idle 1.
    @(negedge CLK);
    P_DATA = 8'h01; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    tick(1'b1, line, b);
    check("dvtick_bit", 32'(line), 32'd1);
    check("dvtick_busy_before", 32'(b), 32'd0);
    check("dvtick_busy_after", 32'(busy), 32'd1);
    frame_ticks(8'h01, 1'b0, 1'b0, -1, 1'b0, "x01");

    // Mid-frame request ignored; request on the STOP->IDLE tick ignored too.
    accept(8'h3C, 1'b1, 1'b0);
    frame_ticks(8'h3C, 1'b1, 1'b0, 4, 1'b1, "glitch");
    repeat (3) @(posedge CLK);
    #1;
    check("post_busy", 32'(busy), 32'd0);
    tick(1'b0, line, b);
    check("post_idle_bit", 32'(line), 32'd1);

    // New request after busy=0 is accepted.
    accept(8'h96, 1'b1, 1'b1);
    frame_ticks(8'h96, 1'b1, 1'b1, -1, 1'b0, "x96");

    // 0x00 with parity: frame ends in the stop bit(s).
    accept(8'h00, 1'b1, 1'b0);
    frame_ticks(8'h00, 1'b1, 1'b0, -1, 1'b0, "x00");

    // No ticks: state and outputs hold.
    accept(8'hC3, 1'b1, 1'b1);
    repeat (40) @(posedge CLK);
    @(negedge CLK);
    check("hold_sel", 32'(MUX_SEL), 32'd0);
    check("hold_busy", 32'(busy), 32'd1);

    // Async reset mid-frame (par_bit=1 for 0xA5 odd).
    accept(8'hA5, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, line, b);
    @(negedge CLK);
    check("pre_rst_sel", 32'(MUX_SEL), 32'd1);
    #1;
    RST = 1'b0;
    #1;
    check("midrst_sel", 32'(MUX_SEL), 32'd3);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_par", 32'(par_bit), 32'd0);
    check("midrst_ser", 32'(ser_data), 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    accept(8'h5A, 1'b0, 1'b0);
    frame_ticks(8'h5A, 1'b0, 1'b0, -1, 1'b0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Hard time bound so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
